rice_enc_ctrl: RTL and testbench

//  Sequencer and adaptive-k controller for the 8-bit Rice encoder datapath.
//  - Accepts samples over a valid/ready handshake and drives the encoder's data/k inputs.
//  - Captures the encoded word, flags codes that overflow 16 bits as escapes, and presents results downstream.
//  - Re-estimates k once per block of samples from the running sample sum.

---
 rtl/rice_enc_ctrl_if.sv | 22 ++
 rtl/rice_enc_ctrl.sv | 110 +++++++++++
 tb/tb_rice_enc_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rice_enc_ctrl_if.sv
// Sample-in / code-out stream bundle of the Rice encoder controller.
interface rice_enc_ctrl_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_code;
  logic [4:0]  out_len;
  logic [3:0]  out_k;
  logic        out_escape;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_code, out_len, out_k, out_escape, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_code, out_len, out_k, out_escape, out_valid
  );
endinterface

// File: rtl/rice_enc_ctrl.sv
// Rice encoder sequencer: one sample per 4-cycle pass, escape detection,
// and per-block k re-estimation from the running sample sum.
module rice_enc_ctrl #(
  parameter int BLOCK_LEN = 16,
  parameter int K_INIT    = 2,
  parameter int K_MAX     = 7
) (
  input  logic        CLK,
  input  logic        reset,
  rice_enc_ctrl_if.slave s,
  output logic [7:0]  enc_data,
  output logic [3:0]  enc_k,
  input  logic [15:0] enc_code,
  output logic [3:0]  cur_k,
  output logic        blk_done
);
  localparam int CW = $clog2(BLOCK_LEN);
  localparam int SW = 8 + CW;

  typedef enum logic [1:0] {IDLE, ENC, LATCH, OUT} state_t;
  state_t state, state_nxt;

  logic [SW-1:0] sum, sum_next;
  logic [CW-1:0] count;
  logic [4:0]    len_r;
  logic          esc_r;
  logic [7:0]    q;
  logic [8:0]    len;
  logic          esc, last;
  logic [3:0]    k_new;
  logic [16:0]   mask;

  assign s.in_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s.in_valid) state_nxt = ENC;
      ENC:     state_nxt = LATCH;
      LATCH:   state_nxt = OUT;
      OUT:     if (s.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Code geometry is fixed at acceptance from the incoming sample and cur_k,
  // which is exactly what enc_k will carry for this sample.
  always_comb begin
    q        = s.in_data >> cur_k;
    len      = 9'(q) + 9'd1 + 9'(cur_k);
    esc      = len > 9'd16;
    sum_next = sum + SW'(s.in_data);
    last     = (count == CW'(BLOCK_LEN - 1));
    mask     = (17'd1 << len_r) - 17'd1;
    k_new    = 4'(K_MAX);
    // Walk downward so the smallest qualifying k wins.
    for (int k = K_MAX; k >= 0; k--)
      if (32'(sum_next) < (32'(BLOCK_LEN) << (k + 1))) k_new = 4'(k);
  end

  always_ff @(posedge CLK or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      enc_data     <= '0;
      enc_k        <= 4'(K_INIT);
      cur_k        <= 4'(K_INIT);
      sum          <= '0;
      count        <= '0;
      blk_done     <= 1'b0;
      len_r        <= '0;
      esc_r        <= 1'b0;
      s.out_code   <= '0;
      s.out_len    <= '0;
      s.out_k      <= '0;
      s.out_escape <= 1'b0;
      s.out_valid  <= 1'b0;
    end else begin
      blk_done <= 1'b0;
      case (state)
        IDLE: if (s.in_valid) begin
          enc_data <= s.in_data;
          enc_k    <= cur_k;
          len_r    <= esc ? 5'd8 : len[4:0];
          esc_r    <= esc;
          if (last) begin
            cur_k    <= k_new;
            sum      <= '0;
            count    <= '0;
            blk_done <= 1'b1;
          end else begin
            sum   <= sum_next;
            count <= count + CW'(1);
          end
        end
        LATCH: begin
          s.out_code   <= esc_r ? {8'h00, enc_data} : (enc_code & mask[15:0]);
          s.out_len    <= len_r;
          s.out_k      <= enc_k;
          s.out_escape <= esc_r;
          s.out_valid  <= 1'b1;
        end
        OUT: if (s.out_ready) s.out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rice_enc_ctrl.sv
// Random + directed bench for rice_enc_ctrl against a sample-level reference model.
module tb_rice_enc_ctrl;
  localparam int BLOCK_LEN = 16;
  localparam int K_INIT    = 2;
  localparam int K_MAX     = 7;

  logic        CLK = 1'b0;
  logic        reset;
  logic [7:0]  enc_data;
  logic [3:0]  enc_k;
  logic [15:0] enc_code;
  logic [3:0]  cur_k;
  logic        blk_done;

  rice_enc_ctrl_if bus ();

  rice_enc_ctrl #(.BLOCK_LEN(BLOCK_LEN), .K_INIT(K_INIT), .K_MAX(K_MAX)) dut (
    .CLK(CLK), .reset(reset), .s(bus.slave),
    .enc_data(enc_data), .enc_k(enc_k), .enc_code(enc_code),
    .cur_k(cur_k), .blk_done(blk_done)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  int mk, msum, mcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference code for one sample: q ones, a 0, then the k-bit remainder.
  function automatic void ref_code(input int d, input int k,
                                   output logic [15:0] code, output int len, output bit esc);
    int qv = d >> k;
    int l  = qv + 1 + k;
    if (l > 16) begin
      esc = 1; len = 8; code = 16'(d);
    end else begin
      esc = 0; len = l;
      code = 16'(((((1 << qv) - 1) << (k + 1)) | (d & ((1 << k) - 1))));
    end
  endfunction

  // Encoder model: correct code, with random junk above the code length.
  function automatic logic [15:0] enc_model(input logic [7:0] d, input logic [3:0] k);
    logic [15:0] c; int l; bit e; logic [15:0] junk;
    ref_code(int'(d), int'(k), c, l, e);
    junk = 16'($urandom);
    if (e) return junk;
    return c | (l >= 16 ? 16'h0 : (junk & ~16'((1 << l) - 1)));
  endfunction

  always @(posedge CLK) enc_code <= enc_model(enc_data, enc_k);

  task automatic model_reset();
    mk = K_INIT; msum = 0; mcnt = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_sample(input logic [7:0] d, input int hold);
    logic [15:0] ecode; int elen; bit eesc; int kused; bit eblk;
    @(negedge CLK);
    chk("in_ready_idle", 32'(bus.in_ready), 1);
    bus.in_data = d; bus.in_valid = 1'b1;
    kused = mk;
    ref_code(int'(d), kused, ecode, elen, eesc);
    msum += int'(d); mcnt++;
    eblk = (mcnt == BLOCK_LEN);
    if (eblk) begin
      mk = K_MAX;
      for (int k = K_MAX; k >= 0; k--) if (msum < (BLOCK_LEN << (k + 1))) mk = k;
      msum = 0; mcnt = 0;
    end
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    chk("blk_done", 32'(blk_done), 32'(eblk));
    chk("cur_k", 32'(cur_k), 32'(mk));
    chk("enc_k", 32'(enc_k), 32'(kused));
    chk("in_ready_busy", 32'(bus.in_ready), 0);
    @(posedge CLK); #1;
    chk("valid_early", 32'(bus.out_valid), 0);
    @(posedge CLK); #1;
    chk("valid_lat", 32'(bus.out_valid), 1);
    chk("out_code", 32'(bus.out_code), 32'(ecode));
    chk("out_len", 32'(bus.out_len), 32'(elen));
    chk("out_k", 32'(bus.out_k), 32'(kused));
    chk("out_escape", 32'(bus.out_escape), 32'(eesc));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'($urandom);
      @(posedge CLK); #1;
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_code", 32'(bus.out_code), 32'(ecode));
      chk("hold_len", 32'(bus.out_len), 32'(elen));
      chk("hold_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge CLK); #1;
    bus.out_ready = 1'b0;
    chk("drain_valid", 32'(bus.out_valid), 0);
    chk("drain_ready", 32'(bus.in_ready), 1);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_cur_k", 32'(cur_k), 2);
    chk("rst_enc_k", 32'(enc_k), 2);
    reset = 1'b0;

    do_sample(8'd13, 0);
    chk("t1_fixed_code", 32'(bus.out_code), 32'h39);
    do_sample(8'd77, 5);
    do_sample(8'd255, 1);
    chk("t3_fixed_code", 32'(bus.out_code), 32'hFF);

    do_reset();
    for (int i = 0; i < 17; i++) do_sample(8'd40, 0);
    chk("t4_k", 32'(cur_k), 5);
    do_reset();
    for (int i = 0; i < 16; i++) do_sample(8'd0, 0);
    chk("t5_k", 32'(cur_k), 0);
    do_sample(8'd3, 0);
    chk("t5_len", 32'(bus.out_len), 4);

    // Reset while a sample sits in LATCH, after building a large partial sum.
    do_reset();
    for (int i = 0; i < 5; i++) do_sample(8'd255, 0);
    @(negedge CLK);
    bus.in_data = 8'd99; bus.in_valid = 1'b1;
    @(posedge CLK); #1; bus.in_valid = 1'b0;
    @(posedge CLK); #1;
    reset = 1'b1; #1;
    chk("t6_valid", 32'(bus.out_valid), 0);
    chk("t6_cur_k", 32'(cur_k), 2);
    @(negedge CLK); reset = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    chk("t6_no_out", 32'(bus.out_valid), 0);
    for (int i = 0; i < 16; i++) do_sample(8'd1, 0);
    chk("t6_k", 32'(cur_k), 0);

    for (int b = 0; b < 5; b++) begin
      int sh = $urandom_range(0, 7);
      for (int i = 0; i < BLOCK_LEN; i++)
        do_sample(8'($urandom) >> sh, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
